win_sprite_animator: RTL and testbench

- Upstream motion stage for the 32x32 win-screen sprite renderer. Supplies the sprite's top-left `x_pos`/`y_pos` and a `show` qualifier, which downstream logic ANDs with the renderer's `visible`.
- On a win pulse the sprite drops from the top of the screen to a rest line, then bounces diagonally inside the 640x480 active area until stopped.
- Positions update only once per frame, at the start of vertical blanking, so a frame is never drawn with a mid-scan move.

---
 rtl/win_sprite_animator.sv | 147 ++++++++++++++
 tb/tb_win_sprite_animator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/win_sprite_animator.sv
// Motion generator for the win-screen sprite. It drops the sprite to a rest line,
// then bounces it around the active area. Positions move once per frame during vblank.
module win_sprite_animator #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SPRITE_SIZE = 32,
  parameter int START_X     = 304,
  parameter int REST_Y      = 224,
  parameter int DROP_STEP   = 4,
  parameter int STEP_X      = 2,
  parameter int STEP_Y      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       show,
  output logic       frame_tick,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DROP   = 2'b01,
    BOUNCE = 2'b10
  } state_t;

  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - SPRITE_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - SPRITE_SIZE);
  localparam logic [10:0] REST_W = 11'(REST_Y);

  state_t     state, state_next;
  logic [9:0] x_next, y_next;
  logic       show_next;
  logic       dir_x, dir_y, dir_x_next, dir_y_next;
  logic       cond, cond_d;
  logic [10:0] drop_sum;
  logic [10:0] x_step, y_step;

  // One bounce step on one axis; result is {flip, new_position}.
  // Positions are clamped at the wall instead of wrapping.
  function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] step, input logic [10:0] limit);
    logic [10:0] p;
    logic [10:0] cand;
    p = {1'b0, pos};
    if (dir) begin
      cand = p + step;
      if (cand > limit) axis_step = {1'b1, limit[9:0]};
      else              axis_step = {1'b0, cand[9:0]};
    end else begin
      cand = p - step;
      if (p < step) axis_step = {1'b1, 10'd0};
      else          axis_step = {1'b0, cand[9:0]};
    end
  endfunction

  assign cond      = (h_count == 10'd0) && (v_count == 10'(V_ACTIVE));
  assign drop_sum  = {1'b0, y_pos} + 11'(DROP_STEP);
  assign x_step    = axis_step(x_pos, dir_x, 11'(STEP_X), X_MAX);
  assign y_step    = axis_step(y_pos, dir_y, 11'(STEP_Y), Y_MAX);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x_pos      <= 10'(START_X);
      y_pos      <= 10'd0;
      show       <= 1'b0;
      frame_tick <= 1'b0;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      cond_d     <= 1'b0;
    end else begin
      state      <= state_next;
      x_pos      <= x_next;
      y_pos      <= y_next;
      show       <= show_next;
      frame_tick <= cond && !cond_d;
      dir_x      <= dir_x_next;
      dir_y      <= dir_y_next;
      cond_d     <= cond;
    end
  end

  // Movement is gated by the registered tick, so it lands one clock later, still in vblank.
  always_comb begin
    state_next = state;
    x_next     = x_pos;
    y_next     = y_pos;
    show_next  = show;
    dir_x_next = dir_x;
    dir_y_next = dir_y;
    if (stop) begin
      state_next = IDLE;
      x_next     = 10'(START_X);
      y_next     = 10'd0;
      show_next  = 1'b0;
      dir_x_next = 1'b1;
      dir_y_next = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          x_next    = 10'(START_X);
          y_next    = 10'd0;
          show_next = 1'b0;
          if (start) begin
            state_next = DROP;
            show_next  = 1'b1;
          end
        end
        DROP: begin
          x_next = 10'(START_X);
          if (frame_tick) begin
            if (drop_sum >= REST_W) begin
              y_next     = REST_W[9:0];
              state_next = BOUNCE;
              dir_x_next = 1'b1;
              dir_y_next = 1'b1;
            end else begin
              y_next = drop_sum[9:0];
            end
          end
        end
        BOUNCE: begin
          if (frame_tick) begin
            x_next     = x_step[9:0];
            y_next     = y_step[9:0];
            dir_x_next = dir_x ^ x_step[10];
            dir_y_next = dir_y ^ y_step[10];
          end
        end
        default: begin
          state_next = IDLE;
          x_next     = 10'(START_X);
          y_next     = 10'd0;
          show_next  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_win_sprite_animator.sv
// Bench for win_sprite_animator: vector table, hand sequences for drop/bounce/priority/reset,
// and a randomized phase compared against an integer model of the sprite's motion.
module tb_win_sprite_animator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [9:0] h_count = 10'd5;
  logic [9:0] v_count = 10'd0;
  logic [9:0] x_pos, y_pos;
  logic       show, frame_tick;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  win_sprite_animator dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .h_count(h_count), .v_count(v_count),
    .x_pos(x_pos), .y_pos(y_pos), .show(show),
    .frame_tick(frame_tick), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 dropping, 2 bouncing; directions are +1/-1.
  int m_mode = 0, m_x = 304, m_y = 0, m_dx = 1, m_dy = 1;
  bit m_show = 0, m_tick = 0, m_cond_d = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_x = 304; m_y = 0; m_dx = 1; m_dy = 1;
      m_show = 0; m_tick = 0; m_cond_d = 0;
    end else begin
      bit c;
      int nx, ny;
      c = (h_count == 0) && (v_count == 480);
      if (stop) begin
        m_mode = 0; m_x = 304; m_y = 0; m_show = 0; m_dx = 1; m_dy = 1;
      end else if (m_mode == 0) begin
        if (start) begin m_mode = 1; m_show = 1; end
      end else if (m_mode == 1) begin
        if (m_tick) begin
          if (m_y + 4 >= 224) begin m_y = 224; m_mode = 2; m_dx = 1; m_dy = 1; end
          else m_y = m_y + 4;
        end
      end else if (m_tick) begin
        nx = m_x + 2 * m_dx;
        if (m_dx > 0 && nx > 608) begin m_x = 608; m_dx = -1; end
        else if (m_dx < 0 && m_x < 2) begin m_x = 0; m_dx = 1; end
        else m_x = nx;
        ny = m_y + m_dy;
        if (m_dy > 0 && ny > 448) begin m_y = 448; m_dy = -1; end
        else if (m_dy < 0 && m_y < 1) begin m_y = 0; m_dy = 1; end
        else m_y = ny;
      end
      m_tick = c && !m_cond_d;
      m_cond_d = c;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".x"}, int'(x_pos), m_x);
    chk({tag, ".y"}, int'(y_pos), m_y);
    chk({tag, ".show"}, int'(show), int'(m_show));
    chk({tag, ".tick"}, int'(frame_tick), int'(m_tick));
    chk({tag, ".state"}, int'(state_dbg), m_mode);
    chk({tag, ".xlim"}, int'(x_pos <= 608), 1);
    chk({tag, ".ylim"}, int'(y_pos <= 448), 1);
  endtask

  // Drive inputs just after a falling edge; return at the next falling edge.
  task automatic apply(input bit st, input bit sp, input int h, input int v);
    start = st; stop = sp; h_count = 10'(h); v_count = 10'(v);
    @(negedge clk);
  endtask

  task automatic frame();
    apply(0, 0, 0, 480);
    apply(0, 0, 1, 480);
    apply(0, 0, 1, 0);
  endtask

  typedef struct {
    bit st; bit sp; int h; int v;
    bit e_tick; int e_state; bit e_show; int e_x; int e_y;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{0, 0, 5, 480, 0, 0, 0, 304, 0};
    tbl[1]  = '{0, 0, 0, 480, 1, 0, 0, 304, 0};
    tbl[2]  = '{0, 0, 0, 480, 0, 0, 0, 304, 0};
    tbl[3]  = '{0, 0, 0, 480, 0, 0, 0, 304, 0};
    tbl[4]  = '{0, 0, 0, 480, 0, 0, 0, 304, 0};
    tbl[5]  = '{0, 0, 1, 480, 0, 0, 0, 304, 0};
    tbl[6]  = '{0, 0, 0, 100, 0, 0, 0, 304, 0};
    tbl[7]  = '{1, 0, 3, 10,  0, 1, 1, 304, 0};
    tbl[8]  = '{0, 0, 0, 480, 1, 1, 1, 304, 0};
    tbl[9]  = '{0, 0, 7, 480, 0, 1, 1, 304, 4};
    tbl[10] = '{0, 0, 0, 480, 1, 1, 1, 304, 4};
    tbl[11] = '{0, 1, 0, 480, 0, 0, 0, 304, 0};
    tbl[12] = '{1, 1, 2, 0,   0, 0, 0, 304, 0};
    tbl[13] = '{1, 0, 2, 0,   0, 1, 1, 304, 0};
    tbl[14] = '{0, 0, 2, 0,   0, 1, 1, 304, 0};

    repeat (3) @(negedge clk);
    chk("rst.x", int'(x_pos), 304);
    chk("rst.y", int'(y_pos), 0);
    chk("rst.show", int'(show), 0);
    chk("rst.tick", int'(frame_tick), 0);
    chk("rst.state", int'(state_dbg), 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].st, tbl[i].sp, tbl[i].h, tbl[i].v);
      chk($sformatf("vec%0d.tick", i), int'(frame_tick), int'(tbl[i].e_tick));
      chk($sformatf("vec%0d.state", i), int'(state_dbg), tbl[i].e_state);
      chk($sformatf("vec%0d.show", i), int'(show), int'(tbl[i].e_show));
      chk($sformatf("vec%0d.x", i), int'(x_pos), tbl[i].e_x);
      chk($sformatf("vec%0d.y", i), int'(y_pos), tbl[i].e_y);
    end

    for (int k = 1; k <= 56; k++) begin
      frame();
      chk($sformatf("drop%0d.y", k), int'(y_pos), 4 * k);
      chk($sformatf("drop%0d.x", k), int'(x_pos), 304);
      chk($sformatf("drop%0d.state", k), int'(state_dbg), (k == 56) ? 2 : 1);
      check_model($sformatf("drop%0d", k));
    end

    for (int j = 1; j <= 300; j++) begin
      frame();
      check_model($sformatf("bounce%0d", j));
      if (j == 152) chk("edge_x_reach", int'(x_pos), 608);
      if (j == 153) chk("edge_x_hold", int'(x_pos), 608);
      if (j == 154) chk("edge_x_back", int'(x_pos), 606);
      if (j == 224) chk("edge_y_reach", int'(y_pos), 448);
      if (j == 225) chk("edge_y_hold", int'(y_pos), 448);
      if (j == 226) chk("edge_y_back", int'(y_pos), 447);
    end

    apply(1, 1, 0, 480);
    chk("prio.state", int'(state_dbg), 0);
    chk("prio.show", int'(show), 0);
    chk("prio.x", int'(x_pos), 304);
    chk("prio.y", int'(y_pos), 0);
    apply(0, 0, 1, 0);
    check_model("prio_after");

    for (int n = 0; n < 3000; n++) begin
      bit st, sp;
      int h, v;
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 499) == 0);
      h = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 799);
      v = ($urandom_range(0, 1) == 0) ? 480 : $urandom_range(0, 524);
      apply(st, sp, h, v);
      check_model($sformatf("rand%0d", n));
    end

    apply(0, 1, 1, 0);
    apply(1, 0, 1, 0);
    for (int k = 1; k <= 25; k++) frame();
    chk("pre_async.y", int'(y_pos), 100);
    chk("pre_async.state", int'(state_dbg), 1);
    #2 rst = 1'b1;
    #1;
    chk("async.x", int'(x_pos), 304);
    chk("async.y", int'(y_pos), 0);
    chk("async.show", int'(show), 0);
    chk("async.tick", int'(frame_tick), 0);
    chk("async.state", int'(state_dbg), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(0, 0, 0, 480);
    check_model("post_async");
    apply(0, 0, 1, 480);
    check_model("post_async2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
